// File: rtl/bcd_div.sv
// bcd_div: sequential two-digit BCD divider.
// Divides a two-digit BCD dividend by a one-digit BCD divisor using repeated
// subtraction, returning a two-digit BCD quotient and a one-digit BCD
// remainder. A start/busy/done handshake frames each operation; err flags a
// zero divisor or any non-BCD input nibble.
module bcd_div (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      SUB   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     state, state_nxt;

   // Operands captured on the accepting edge; later input changes are ignored.
   logic [7:0] dividend_q, dividend_nxt;
   logic [3:0] divisor_q, divisor_nxt;

   // Binary working remainder (max 99) and BCD quotient counter (max 99).
   logic [6:0] work, work_nxt;
   logic [7:0] count, count_nxt;

   // Result registers: only change on entry to DONE, held otherwise.
   logic [7:0] quotient_nxt;
   logic [3:0] remainder_nxt;
   logic       err_nxt;

   // True when a nibble is not a legal BCD digit.
   function automatic logic digit_bad(input logic [3:0] d);
      return d > 4'd9;
   endfunction

   // Two BCD digits to binary: tens*10 + units, computed as tens*8 + tens*2.
   function automatic logic [6:0] bcd_to_bin(input logic [7:0] d);
      logic [6:0] tens;
      tens = {3'b000, d[7:4]};
      return (tens << 3) + (tens << 1) + {3'b000, d[3:0]};
   endfunction

   // Two-digit BCD increment; units wrap 9->0 with a carry into tens.
   // The counter never passes 99, so the tens digit needs no wrap.
   function automatic logic [7:0] bcd_inc(input logic [7:0] c);
      if (c[3:0] == 4'd9)
         return {c[7:4] + 4'd1, 4'd0};
      else
         return {c[7:4], c[3:0] + 4'd1};
   endfunction

   logic operand_error;
   assign operand_error = (divisor_q == 4'd0) || digit_bad(divisor_q) ||
                          digit_bad(dividend_q[7:4]) || digit_bad(dividend_q[3:0]);

   // Register every piece of state; reset discards any operation in flight.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         dividend_q <= 8'h00;
         divisor_q  <= 4'h0;
         work       <= 7'd0;
         count      <= 8'h00;
         quotient   <= 8'h00;
         remainder  <= 4'h0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         dividend_q <= dividend_nxt;
         divisor_q  <= divisor_nxt;
         work       <= work_nxt;
         count      <= count_nxt;
         quotient   <= quotient_nxt;
         remainder  <= remainder_nxt;
         err        <= err_nxt;
      end
   end

   // Next-state and datapath decisions for the handshake and subtraction loop.
   // NOTE: every variable gets a hold-value default before the case, so no
   // path through the block leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt     = state;
      dividend_nxt  = dividend_q;
      divisor_nxt   = divisor_q;
      work_nxt      = work;
      count_nxt     = count;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      err_nxt       = err;

      unique case (state)
         IDLE: begin
            if (start) begin
               dividend_nxt = dividend;
               divisor_nxt  = divisor;
               state_nxt    = CHECK;
            end
         end

         CHECK: begin
            if (operand_error) begin
               quotient_nxt  = 8'h00;
               remainder_nxt = 4'h0;
               err_nxt       = 1'b1;
               state_nxt     = DONE;
            end else begin
               work_nxt  = bcd_to_bin(dividend_q);
               count_nxt = 8'h00;
               state_nxt = SUB;
            end
         end

         SUB: begin
            if (work >= {3'b000, divisor_q}) begin
               work_nxt  = work - {3'b000, divisor_q};
               count_nxt = bcd_inc(count);
            end else begin
               // Loop exit: remainder is below the divisor, hence below 10.
               quotient_nxt  = count;
               remainder_nxt = work[3:0];
               err_nxt       = 1'b0;
               state_nxt     = DONE;
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Handshake outputs decode directly from state, so they never overlap.
   assign busy = (state == CHECK) || (state == SUB);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bcd_div.sv
// tb_bcd_div: self-checking bench for bcd_div.
// A transaction-level model computes each result with integer division and
// the expected handshake timing from the quotient; a negedge compare process
// checks all outputs against it every cycle. Directed tasks add hand-computed
// result and latency expectations.
module tb_bcd_div;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   bcd_div dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int n);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(n / 10);
      u = 4'(n % 10);
      return {t, u};
   endfunction

   // ---------------- reference model (transaction level) ----------------
   // phase: 0 idle, 1 busy, 2 done pulse
   int         m_phase = 0;
   int         m_left  = 0;
   logic [7:0] e_q     = 8'h00;
   logic [3:0] e_r     = 4'h0;
   logic       e_err   = 1'b0;
   logic [7:0] p_q;
   logic [3:0] p_r;
   logic       p_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0;
         m_left  = 0;
         e_q     = 8'h00;
         e_r     = 4'h0;
         e_err   = 1'b0;
      end else begin
         case (m_phase)
            0: if (start) begin
               int tens, units, dvs, value;
               tens  = int'(dividend[7:4]);
               units = int'(dividend[3:0]);
               dvs   = int'(divisor);
               if (dvs == 0 || dvs > 9 || tens > 9 || units > 9) begin
                  p_q = 8'h00; p_r = 4'h0; p_err = 1'b1;
                  m_left = 1;
               end else begin
                  value = tens * 10 + units;
                  p_q = to_bcd(value / dvs);
                  p_r = 4'(value % dvs);
                  p_err = 1'b0;
                  m_left = value / dvs + 2;
               end
               m_phase = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = 2;
                  e_q = p_q; e_r = p_r; e_err = p_err;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      check("cycle {busy,done,err,rem,quot}",
            32'({busy, done, err, remainder, quotient}),
            32'({m_phase == 1, m_phase == 2, e_err, e_r, e_q}));
   end

   // ---------------- directed stimulus ----------------
   // Wait for done, counting edges after E0; then check literal expectations.
   task automatic wait_done(input int e_start, input logic [7:0] xq, input logic [3:0] xr,
                            input logic xerr, input int lat, input bit carry);
      int edges;
      edges = e_start;
      while (!done && edges < 200) begin
         @(negedge clk);
         edges++;
         if (carry && edges >= 11 && edges <= 91 && ((edges - 1) % 10) == 0)
            check("carry count", 32'(dut.count), 32'(to_bcd(edges - 1)));
      end
      check("latency", 32'(edges), 32'(lat));
      check("quotient", 32'(quotient), 32'(xq));
      check("remainder", 32'(remainder), 32'(xr));
      check("err", 32'(err), 32'(xerr));
   endtask

   task automatic launch(input logic [7:0] a, input logic [3:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] xq,
                         input logic [3:0] xr, input logic xerr, input int lat, input bit carry);
      launch(a, b);
      wait_done(0, xq, xr, xerr, lat, carry);
   endtask

   initial begin
      start    = 1'b0;
      dividend = 8'h00;
      divisor  = 4'h0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      check("reset quotient", 32'(quotient), 32'h00);
      check("reset remainder", 32'(remainder), 32'h0);
      check("reset busy/done/err", 32'({busy, done, err}), 32'h0);
      rst = 1'b0;

      run_op(8'h75, 4'h8, 8'h09, 4'h3, 1'b0, 11, 1'b0);
      run_op(8'h99, 4'h1, 8'h99, 4'h0, 1'b0, 101, 1'b1);
      run_op(8'h07, 4'h9, 8'h00, 4'h7, 1'b0, 2, 1'b0);
      run_op(8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 2, 1'b0);
      run_op(8'h42, 4'h0, 8'h00, 4'h0, 1'b1, 1, 1'b0);
      run_op(8'h1A, 4'h3, 8'h00, 4'h0, 1'b1, 1, 1'b0);
      run_op(8'h20, 4'hA, 8'h00, 4'h0, 1'b1, 1, 1'b0);
      run_op(8'h42, 4'h6, 8'h07, 4'h0, 1'b0, 9, 1'b0);

      // start and input changes while busy are ignored
      launch(8'h50, 4'h1);
      repeat (5) @(negedge clk);
      dividend = 8'h12;
      divisor  = 4'h3;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = 8'h33;
      divisor  = 4'h7;
      wait_done(6, 8'h50, 4'h0, 1'b0, 52, 1'b0);

      // start held high: re-accepted on the first edge back in IDLE
      @(negedge clk);
      dividend = 8'h07;
      divisor  = 4'h9;
      start    = 1'b1;
      repeat (9) @(negedge clk);
      start    = 1'b0;
      repeat (4) @(negedge clk);

      // asynchronous reset in the middle of 99/1
      launch(8'h99, 4'h1);
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async reset quotient", 32'(quotient), 32'h00);
      check("async reset remainder", 32'(remainder), 32'h0);
      check("async reset busy/done/err", 32'({busy, done, err}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (110) @(negedge clk);
      run_op(8'h64, 4'h8, 8'h08, 4'h0, 1'b0, 10, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
